// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // A fetch target must be word aligned; low address bits flag a bad target.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next-PC priority mux: trap, then redirect, then sequential advance, else hold.
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic        trap_i,
  input  logic        redirect_i,
  input  logic        advance_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] trap_vector_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_det_o
);

  // Select the next PC; a misaligned redirect falls back to the trap vector.
  always_comb begin
    next_pc_o        = pc_i;
    misaligned_det_o = 1'b0;
    if (trap_i) begin
      next_pc_o = trap_vector_i;
    end else if (redirect_i) begin
      if (is_misaligned(redirect_pc_i)) begin
        next_pc_o        = trap_vector_i;
        misaligned_det_o = 1'b1;
      end else begin
        next_pc_o = redirect_pc_i;
      end
    end else if (advance_i) begin
      next_pc_o = pc_i + PC_STEP;
    end else begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a time and holds
// the returned instruction for decode until it is accepted or flushed.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        misaligned_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         misaligned_q, misaligned_d;
  logic         kill_q, kill_d;

  logic         active_s;
  logic         flush_s;
  logic         advance_s;
  logic         capture_s;
  logic [31:0]  sel_pc_s;
  logic         sel_mis_s;

  // IDLE is the one cycle after reset where no PC update is considered.
  assign active_s  = (state_q != ST_IDLE);
  assign flush_s   = active_s & (trap_i | redirect_valid_i);
  assign advance_s = (state_q == ST_HOLD) & id_ready_i & ~flush_s;
  assign capture_s = (state_q == ST_WAIT) & imem_rvalid_i & ~kill_q & ~flush_s;

  pc_next_sel u_pc_next_sel (
    .trap_i           (active_s & trap_i),
    .redirect_i       (active_s & redirect_valid_i),
    .advance_i        (advance_s),
    .pc_i             (pc_q),
    .redirect_pc_i    (redirect_pc_i),
    .trap_vector_i    (TRAP_VECTOR),
    .next_pc_o        (sel_pc_s),
    .misaligned_det_o (sel_mis_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush always restarts fetching from REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt_i) begin
          state_d = ST_WAIT;
        end else if (flush_s) begin
          state_d = ST_REQ;
        end else if (halt_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = (kill_q || flush_s) ? ST_REQ : ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush_s) begin
          state_d = ST_REQ;
        end else if (id_ready_i) begin
          state_d = halt_i ? ST_HALTED : ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_d = flush_s ? ST_REQ : ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; kill marks an in-flight response as stale.
  always_comb begin
    imem_req_o   = (state_q == ST_REQ);
    pc_d         = sel_pc_s;
    misaligned_d = sel_mis_s;
    id_valid_d   = (state_d == ST_HOLD);
    id_instr_d   = capture_s ? imem_rdata_i : id_instr_q;
    id_pc_d      = capture_s ? pc_q : id_pc_q;
    kill_d       = kill_q;
    case (state_q)
      ST_REQ: begin
        if (imem_gnt_i && flush_s) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
        end else if (flush_s) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      default: begin
        kill_d = kill_q;
      end
    endcase
  end

  // Datapath registers: PC, decode handoff and misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= 32'h0000_0000;
      misaligned_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      misaligned_q <= misaligned_d;
      kill_q       <= kill_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign id_valid_o   = id_valid_q;
  assign id_instr_o   = id_instr_q;
  assign id_pc_o      = id_pc_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_i           (trap),
    .halt_i           (halt),
    .pc_o             (pc),
    .misaligned_o     (misaligned)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic rdr, input logic [31:0] rpc, input logic tr, input logic hl);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy;
    redirect_valid = rdr; redirect_pc = rpc; trap = tr; halt = hl;
  endtask

  typedef struct {
    logic gnt; logic rv; logic [31:0] rdata; logic rdy;
    logic rdr; logic [31:0] rpc; logic trp; logic hlt;
    logic e_req; logic [31:0] e_pc; logic e_val;
    logic [31:0] e_instr; logic [31:0] e_ipc; logic e_mis;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic rdr, input logic [31:0] rpc, input logic tr, input logic hl,
                              input logic er, input logic [31:0] ep, input logic ev,
                              input logic [31:0] ei, input logic [31:0] eip, input logic em);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.trp = tr; v.hlt = hl; v.e_req = er; v.e_pc = ep; v.e_val = ev;
    v.e_instr = ei; v.e_ipc = eip; v.e_mis = em;
    return v;
  endfunction

  // Reference model state: an abstract view of the fetch pipeline.
  logic        m_boot, m_wait, m_have, m_stop, m_drop, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc;

  task automatic model_reset();
    m_boot = 1'b1; m_wait = 1'b0; m_have = 1'b0; m_stop = 1'b0; m_drop = 1'b0;
    m_mis = 1'b0; m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
  endtask

  // One clock of the model, applied with the inputs that were present at the edge.
  task automatic model_step();
    logic        flush;
    logic [31:0] target;
    if (m_boot) begin
      m_boot = 1'b0;
      m_mis  = 1'b0;
      return;
    end
    flush  = trap | redirect_valid;
    target = (trap || redirect_pc[1:0] != 2'b00) ? 32'h0000_0100 : redirect_pc;
    m_mis  = !trap && redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (m_have) begin
      if (flush) begin
        m_have = 1'b0;
      end else if (id_ready) begin
        m_have = 1'b0;
        m_pc   = m_pc + 32'd4;
        m_stop = halt;
      end
    end else if (m_stop) begin
      if (flush) m_stop = 1'b0;
    end else if (m_wait) begin
      if (imem_rvalid) begin
        m_wait = 1'b0;
        if (!(m_drop || flush)) begin
          m_have  = 1'b1;
          m_instr = imem_rdata;
          m_ipc   = m_pc;
        end
        m_drop = 1'b0;
      end else if (flush) begin
        m_drop = 1'b1;
      end
    end else begin
      if (imem_gnt) begin
        m_wait = 1'b1;
        m_drop = flush;
      end else if (!flush && halt) begin
        m_stop = 1'b1;
      end
    end
    if (flush) m_pc = target;
  endtask

  vec_t tbl[24];
  localparam logic [31:0] I0 = 32'h00A0_0093;
  localparam logic [31:0] I1 = 32'h0010_8113;
  localparam logic [31:0] I2 = 32'h0020_0193;
  localparam logic [31:0] DD = 32'hDEAD_BEEF;

  initial begin
    //            gnt rv rdata rdy rdr rpc           trp hlt | req pc            val instr ipc           mis
    tbl[0]  = mk(0, 0, 0,  0, 0, 0,             0, 0,   0, 32'h0,         0, 0,  0,            0);
    tbl[1]  = mk(1, 0, 0,  0, 0, 0,             0, 0,   1, 32'h0,         0, 0,  0,            0);
    tbl[2]  = mk(0, 1, I0, 0, 0, 0,             0, 0,   0, 32'h0,         0, 0,  0,            0);
    tbl[3]  = mk(0, 0, 0,  1, 0, 0,             0, 0,   0, 32'h0,         1, I0, 32'h0,        0);
    tbl[4]  = mk(1, 0, 0,  0, 0, 0,             0, 0,   1, 32'h4,         0, 0,  0,            0);
    tbl[5]  = mk(0, 1, I1, 0, 0, 0,             0, 0,   0, 32'h4,         0, 0,  0,            0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, 0,             0, 0,   0, 32'h4,         1, I1, 32'h4,        0);
    tbl[11] = mk(0, 0, 0,  1, 0, 0,             0, 0,   0, 32'h4,         1, I1, 32'h4,        0);
    tbl[12] = mk(1, 0, 0,  0, 0, 0,             0, 0,   1, 32'h8,         0, 0,  0,            0);
    tbl[13] = mk(0, 0, 0,  0, 1, 32'h200,       0, 0,   0, 32'h8,         0, 0,  0,            0);
    tbl[14] = mk(0, 1, DD, 0, 0, 0,             0, 0,   0, 32'h200,       0, 0,  0,            0);
    tbl[15] = mk(0, 0, 0,  0, 1, 32'h300,       1, 0,   1, 32'h200,       0, 0,  0,            0);
    tbl[16] = mk(0, 0, 0,  0, 1, 32'h202,       0, 0,   1, 32'h100,       0, 0,  0,            0);
    tbl[17] = mk(0, 0, 0,  0, 0, 0,             0, 0,   1, 32'h100,       0, 0,  0,            1);
    tbl[18] = mk(1, 0, 0,  0, 0, 0,             0, 0,   1, 32'h100,       0, 0,  0,            0);
    tbl[19] = mk(0, 1, I2, 0, 0, 0,             0, 0,   0, 32'h100,       0, 0,  0,            0);
    tbl[20] = mk(0, 0, 0,  1, 0, 0,             0, 1,   0, 32'h100,       1, I2, 32'h100,      0);
    tbl[21] = mk(0, 0, 0,  0, 0, 0,             0, 0,   0, 32'h104,       0, 0,  0,            0);
    tbl[22] = mk(0, 0, 0,  0, 1, 32'h40,        0, 0,   0, 32'h104,       0, 0,  0,            0);
    tbl[23] = mk(1, 0, 0,  0, 0, 0,             0, 0,   1, 32'h40,        0, 0,  0,            0);

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    rst_n = 1'b1;

    // Directed table: inputs at negedge, outputs reflect state after prior edges.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc,
            tbl[i].trp, tbl[i].hlt);
      #1;
      chk($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_pc);
      chk($sformatf("row%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_val});
      chk($sformatf("row%0d_mis", i), {31'b0, misaligned}, {31'b0, tbl[i].e_mis});
      if (tbl[i].e_val) begin
        chk($sformatf("row%0d_instr", i), id_instr, tbl[i].e_instr);
        chk($sformatf("row%0d_idpc", i), id_pc, tbl[i].e_ipc);
      end
      @(negedge clk);
    end

    // Reset asserted mid-fetch (WAIT), then a late rvalid must be ignored.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wait_req", {31'b0, imem_req}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", {31'b0, id_valid}, 32'h0);
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, DD, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("late_rv_valid", {31'b0, id_valid}, 32'h0);
    chk("late_rv_req", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    chk("late_rv_valid2", {31'b0, id_valid}, 32'h0);
    chk("late_rv_pc", pc, 32'h0);

    // PC wrap: fetch at 0xFFFF_FFFC and advance to 0.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 1, I0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("wrap_valid", {31'b0, id_valid}, 32'h1);
    chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_req", {31'b0, imem_req}, 32'h1);

    // Randomized traffic against the model.
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] r;
      r = $urandom;
      imem_gnt       = ($urandom_range(0, 1) == 1);
      imem_rvalid    = ($urandom_range(0, 1) == 1);
      imem_rdata     = $urandom;
      id_ready       = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 6);
      trap           = ($urandom_range(0, 99) < 3);
      halt           = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 19) == 0) r = 32'hFFFF_FFFC;
      else if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      #1;
      chk("rnd_req", {31'b0, imem_req},
          {31'b0, !m_boot && !m_wait && !m_have && !m_stop});
      chk("rnd_pc", pc, m_pc);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid", {31'b0, id_valid}, {31'b0, m_have});
      chk("rnd_mis", {31'b0, misaligned}, {31'b0, m_mis});
      if (m_have) begin
        chk("rnd_instr", id_instr, m_instr);
        chk("rnd_idpc", id_pc, m_ipc);
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
